// File: rtl/recir_pkg.sv
// recir_pkg: shared definitions for the lane recirculation controller.
//   NLANES_DEF / THR_W_DEF : default lane count and threshold width
//   state_t                : FSM state encoding (also visible on recir_ctrl.state)
package recir_pkg;

    localparam int unsigned NLANES_DEF = 4;
    localparam int unsigned THR_W_DEF  = 4;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin lane picker.
//   req      in   NLANES  request vector (lane non-empty)
//   ptr      in   PTR_W   lane with highest priority this cycle
//   grant    out  NLANES  one-hot grant, zero when no request (combinational)
//   next_ptr out  PTR_W   lane after the granted one, wrapping; ptr when no grant
//   any      out  1       a grant was produced
module rr_arbiter #(
    parameter  int unsigned NLANES = 4,
    localparam int unsigned PTR_W  = (NLANES > 1) ? $clog2(NLANES) : 1
) (
    input  logic [NLANES-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NLANES-1:0] grant,
    output logic [PTR_W-1:0]  next_ptr,
    output logic              any
);

    logic [PTR_W-1:0] idx;

    // Scan lanes starting at ptr; first requester wins.
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        any      = 1'b0;
        idx      = '0;
        for (int unsigned i = 0; i < NLANES; i++) begin
            idx = PTR_W'((32'(ptr) + i) % NLANES);
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                next_ptr   = PTR_W'((32'(idx) + 32'd1) % NLANES);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/recir_ctrl.sv
// recir_ctrl: sequencing FSM for the lane recirculation datapath (clk4f domain).
//   Pops the lane FIFOs round-robin and drives the recirculation select.
//   clk4f, reset (sync, active-high), init (pulse: re-enter INIT)
//   umbral_hi/lo          thresholds, latched every cycle spent in INIT
//   fifo_empty/almost_full/error  per-lane FIFO status
//   pop        one-hot pop request (registered)
//   valido     pop delayed one cycle, aligned with FIFO read data
//   pause      registered |fifo_almost_full, 0 in RESET/INIT, 1 in ERROR
//   umbral_hi_q/lo_q, state, idle_out, error_out  registered status
//   Optional macro RECIR_CTRL_STATS_EN adds pop_cnt[NLANES] and idle_cnt
//   saturating counters, cleared on reset and on INIT entry.
module recir_ctrl
    import recir_pkg::*;
#(
    parameter int unsigned NLANES = recir_pkg::NLANES_DEF,
    parameter int unsigned THR_W  = recir_pkg::THR_W_DEF
) (
    input  logic              clk4f,
    input  logic              reset,
    input  logic              init,
    input  logic [THR_W-1:0]  umbral_hi,
    input  logic [THR_W-1:0]  umbral_lo,
    input  logic [NLANES-1:0] fifo_empty,
    input  logic [NLANES-1:0] fifo_almost_full,
    input  logic [NLANES-1:0] fifo_error,
    output logic [NLANES-1:0] pop,
    output logic              valido,
    output logic              pause,
    output logic [THR_W-1:0]  umbral_hi_q,
    output logic [THR_W-1:0]  umbral_lo_q,
    output logic [2:0]        state,
    output logic              idle_out,
    output logic              error_out
`ifdef RECIR_CTRL_STATS_EN
    ,
    output logic [15:0]       pop_cnt [NLANES],
    output logic [15:0]       idle_cnt
`endif
);

    localparam int unsigned PTR_W = (NLANES > 1) ? $clog2(NLANES) : 1;

    state_t            cur;
    logic [PTR_W-1:0]  ptr;
    logic [NLANES-1:0] grant;
    logic [PTR_W-1:0]  next_ptr;
    logic              gnt_any;

    assign state = 3'(cur);

    rr_arbiter #(.NLANES(NLANES)) u_arb (
        .req      (~fifo_empty),
        .ptr      (ptr),
        .grant    (grant),
        .next_ptr (next_ptr),
        .any      (gnt_any)
    );

    // FSM with registered outputs; each branch sets outputs for the state it enters.
    always_ff @(posedge clk4f) begin
        if (reset) begin
            cur         <= ST_RESET;
            pop         <= '0;
            valido      <= 1'b0;
            pause       <= 1'b0;
            umbral_hi_q <= '0;
            umbral_lo_q <= '0;
            ptr         <= '0;
            idle_out    <= 1'b0;
            error_out   <= 1'b0;
        end else begin
            pop       <= '0;
            valido    <= |pop;
            pause     <= |fifo_almost_full;
            idle_out  <= 1'b0;
            error_out <= 1'b0;
            if (cur == ST_INIT) begin
                umbral_hi_q <= umbral_hi;
                umbral_lo_q <= umbral_lo;
            end
            if (cur != ST_RESET && (|fifo_error || cur == ST_ERROR)) begin
                // Error is sticky and overrides every other transition.
                cur       <= ST_ERROR;
                valido    <= 1'b0;
                pause     <= 1'b1;
                error_out <= 1'b1;
            end else begin
                case (cur)
                    ST_RESET: begin
                        cur   <= ST_INIT;
                        pause <= 1'b0;
                    end
                    ST_INIT: begin
                        if (init) begin
                            pause <= 1'b0;
                        end else begin
                            cur      <= ST_IDLE;
                            idle_out <= 1'b1;
                        end
                    end
                    ST_IDLE, ST_ACTIVE: begin
                        if (init) begin
                            // Any pop already issued still yields valido next cycle.
                            cur   <= ST_INIT;
                            pause <= 1'b0;
                        end else if (gnt_any) begin
                            cur <= ST_ACTIVE;
                            pop <= grant;
                            ptr <= next_ptr;
                        end else begin
                            cur      <= ST_IDLE;
                            idle_out <= 1'b1;
                        end
                    end
                    default: begin
                        cur   <= ST_RESET;
                        pause <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef RECIR_CTRL_STATS_EN
    logic serving;
    logic init_entry;
    logic issue;

    assign serving    = (cur == ST_IDLE) || (cur == ST_ACTIVE);
    assign init_entry = (cur == ST_RESET) || (serving && init && !(|fifo_error));
    assign issue      = serving && !init && !(|fifo_error) && gnt_any;

    // Saturating per-lane pop counters and IDLE cycle counter.
    always_ff @(posedge clk4f) begin
        if (reset || init_entry) begin
            for (int unsigned i = 0; i < NLANES; i++) begin
                pop_cnt[i] <= '0;
            end
            idle_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NLANES; i++) begin
                if (issue && grant[i] && pop_cnt[i] != 16'hFFFF) begin
                    pop_cnt[i] <= pop_cnt[i] + 16'd1;
                end
            end
            if (cur == ST_IDLE && idle_cnt != 16'hFFFF) begin
                idle_cnt <= idle_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_recir_ctrl.sv
// tb_recir_ctrl: directed scenarios plus randomized traffic, every cycle compared
// against a behavioural model of the recirculation controller.
module tb_recir_ctrl;

    localparam int M_RESET  = 0;
    localparam int M_INIT   = 1;
    localparam int M_IDLE   = 2;
    localparam int M_ACTIVE = 3;
    localparam int M_ERROR  = 4;

    logic       clk4f = 1'b0;
    logic       reset, init;
    logic [3:0] umbral_hi, umbral_lo;
    logic [3:0] fifo_empty, fifo_almost_full, fifo_error;
    logic [3:0] pop;
    logic       valido, pause;
    logic [3:0] umbral_hi_q, umbral_lo_q;
    logic [2:0] state;
    logic       idle_out, error_out;
`ifdef RECIR_CTRL_STATS_EN
    logic [15:0] pop_cnt [4];
    logic [15:0] idle_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    int m_state = M_RESET;
    int m_ptr   = 0;
    int m_pop   = 0;
    int m_valido = 0;
    int m_pause = 0;
    int m_hi = 0;
    int m_lo = 0;

    always #5 clk4f = ~clk4f;

    recir_ctrl dut (
        .clk4f            (clk4f),
        .reset            (reset),
        .init             (init),
        .umbral_hi        (umbral_hi),
        .umbral_lo        (umbral_lo),
        .fifo_empty       (fifo_empty),
        .fifo_almost_full (fifo_almost_full),
        .fifo_error       (fifo_error),
        .pop              (pop),
        .valido           (valido),
        .pause            (pause),
        .umbral_hi_q      (umbral_hi_q),
        .umbral_lo_q      (umbral_lo_q),
        .state            (state),
        .idle_out         (idle_out),
        .error_out        (error_out)
`ifdef RECIR_CTRL_STATS_EN
        ,
        .pop_cnt          (pop_cnt),
        .idle_cnt         (idle_cnt)
`endif
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        int nstate;
        int grant_lane;
        int npop;
        int nptr;
        if (reset) begin
            m_state = M_RESET; m_ptr = 0; m_pop = 0; m_valido = 0;
            m_pause = 0; m_hi = 0; m_lo = 0;
            return;
        end
        if (m_state == M_INIT) begin
            m_hi = int'(umbral_hi);
            m_lo = int'(umbral_lo);
        end
        grant_lane = -1;
        for (int k = 0; k < 4; k++) begin
            int lane;
            lane = (m_ptr + k) % 4;
            if (grant_lane < 0 && fifo_empty[lane] == 1'b0) grant_lane = lane;
        end
        npop = 0;
        nptr = m_ptr;
        if (m_state == M_ERROR || (m_state != M_RESET && fifo_error != 4'd0)) begin
            nstate = M_ERROR;
        end else if (m_state == M_RESET) begin
            nstate = M_INIT;
        end else if (m_state == M_INIT) begin
            nstate = init ? M_INIT : M_IDLE;
        end else if (init) begin
            nstate = M_INIT;
        end else if (grant_lane >= 0) begin
            nstate = M_ACTIVE;
            npop = 1 << grant_lane;
            nptr = (grant_lane + 1) % 4;
        end else begin
            nstate = M_IDLE;
        end
        m_valido = (nstate == M_ERROR) ? 0 : (m_pop != 0 ? 1 : 0);
        if (nstate == M_ERROR)      m_pause = 1;
        else if (nstate <= M_INIT)  m_pause = 0;
        else                        m_pause = (fifo_almost_full != 4'd0) ? 1 : 0;
        m_pop   = npop;
        m_ptr   = nptr;
        m_state = nstate;
    endtask

    task automatic compare_all();
        check_val("state",     int'(state),       m_state);
        check_val("pop",       int'(pop),         m_pop);
        check_val("valido",    int'(valido),      m_valido);
        check_val("pause",     int'(pause),       m_pause);
        check_val("hi_q",      int'(umbral_hi_q), m_hi);
        check_val("lo_q",      int'(umbral_lo_q), m_lo);
        check_val("idle_out",  int'(idle_out),    (m_state == M_IDLE) ? 1 : 0);
        check_val("error_out", int'(error_out),   (m_state == M_ERROR) ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clk4f);
        model_step();
        @(negedge clk4f);
        compare_all();
    endtask

    initial begin
        reset = 1'b1; init = 1'b0;
        umbral_hi = 4'd6; umbral_lo = 4'd2;
        fifo_empty = 4'hF; fifo_almost_full = 4'h0; fifo_error = 4'h0;

        // 1) reset, init pulse, thresholds latched
        repeat (3) tick();
        check_val("t1_rst_state", int'(state), M_RESET);
        reset = 1'b0;
        tick();
        check_val("t1_init_state", int'(state), M_INIT);
        init = 1'b1;
        tick();
        init = 1'b0;
        tick();
        check_val("t1_idle_state", int'(state), M_IDLE);
        check_val("t1_hi_q", int'(umbral_hi_q), 6);
        check_val("t1_lo_q", int'(umbral_lo_q), 2);

        // 2) single lane-0 request
        fifo_empty = 4'b1110;
        tick();
        check_val("t2_pop", int'(pop), 1);
        fifo_empty = 4'hF;
        tick();
        check_val("t2_valido", int'(valido), 1);
        check_val("t2_idle", int'(state), M_IDLE);
        tick();

        // 3) all lanes busy: rotation with continuous valido
        fifo_empty = 4'h0;
        repeat (8) tick();
        fifo_empty = 4'hF;
        repeat (2) tick();

        // 4) pause follows almost-full with one cycle of latency
        fifo_almost_full = 4'b0100;
        tick();
        check_val("t4_pause_set", int'(pause), 1);
        fifo_almost_full = 4'h0;
        tick();
        check_val("t4_pause_clr", int'(pause), 0);

        // Randomized traffic with occasional reset, init and error
        for (int c = 0; c < 2000; c++) begin
            reset            = ($urandom_range(0, 99) == 0);
            init             = ($urandom_range(0, 39) == 0);
            umbral_hi        = 4'($urandom);
            umbral_lo        = 4'($urandom);
            fifo_empty       = (c % 200 < 100) ? 4'($urandom) : (4'($urandom) | 4'($urandom));
            fifo_almost_full = 4'($urandom) & 4'($urandom);
            fifo_error       = ($urandom_range(0, 299) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            tick();
        end

        // 6) reset mid-ACTIVE; first grant afterwards is lane 0
        reset = 1'b1; init = 1'b0; fifo_error = 4'h0; fifo_almost_full = 4'h0;
        fifo_empty = 4'hF;
        tick();
        reset = 1'b0;
        repeat (2) tick();
        fifo_empty = 4'h0;
        repeat (3) tick();
        check_val("t6_active", int'(state), M_ACTIVE);
        reset = 1'b1;
        tick();
        check_val("t6_rst_state", int'(state), M_RESET);
        check_val("t6_rst_pop", int'(pop), 0);
        check_val("t6_rst_valido", int'(valido), 0);
        reset = 1'b0;
        repeat (2) tick();
        tick();
        check_val("t6_first_grant", int'(pop), 1);

        // 5) error during ACTIVE is sticky and ignores init
        tick();
        fifo_error = 4'b0100;
        tick();
        check_val("t5_err_state", int'(state), M_ERROR);
        check_val("t5_err_pop", int'(pop), 0);
        check_val("t5_err_valido", int'(valido), 0);
        check_val("t5_err_pause", int'(pause), 1);
        fifo_error = 4'h0; init = 1'b1;
        tick();
        init = 1'b0;
        repeat (4) tick();
        check_val("t5_sticky", int'(state), M_ERROR);
        reset = 1'b1;
        tick();
        check_val("t5_exit", int'(state), M_RESET);
        reset = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
